trap_unit: RTL
==============

Name: trap_unit

Overview:
- Trap sequencer that sits directly upstream of the CSR file and decides when a trap or MRET is taken.
- Inputs: per-instruction exception flags from the commit stage, external interrupt lines, and CSR enable bits.
- It drives the CSR trap inputs (exception_flag, exception_cause, epc) for exactly one cycle.
- It then captures the CSR-supplied target PC, flushes the pipeline and hands a redirect to fetch over a valid/ready handshake.

Parameters:
- XLEN, 64, PC/data width.
- SYNC_STAGES, 2, flip-flop depth of interrupt synchronizers (>=2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- ex_valid  in  1  commit-stage instruction valid
- ex_pc  in  XLEN  PC of committing instruction
- ex_inst_misalign, ex_illegal, ex_ebreak, ex_ecall, ex_load_misalign, ex_store_misalign, ex_mret  in  1 each  exception/MRET flags, qualified by ex_valid
- irq_ext, irq_soft, irq_timer  in  1 each  asynchronous level interrupt requests
- csr_mstatus_mie  in  1  global machine interrupt enable
- csr_mie  in  3  {MEIE, MSIE, MTIE} local enables
- exception_target_pc  in  XLEN  trap/MRET target from CSR (combinational)
- exception_flag  out  1  to CSR: take trap/MRET this cycle
- exception_cause  out  5  {interrupt, code[3:0]}, or `MRET
- epc  out  XLEN  PC saved into mepc
- stall_commit  out  1  blocks commit while busy
- flush  out  1  kill all in-flight instructions
- redirect_valid  out  1  fetch redirect request
- redirect_pc  out  XLEN  redirect address
- redirect_ready  in  1  fetch accepts redirect

Behaviour:
- Reset (rst low, async): state IDLE; every output 0; synchronizers cleared.
- Interrupts pass through irq_sync. Effective pending = sync_irq & csr_mie & csr_mstatus_mie.
- Priority, highest first:
  - interrupts: ext 5'h1B, soft 5'h13, timer 5'h17;
  - exceptions: inst_misalign 5'h00, illegal 5'h02, ebreak 5'h03, ecall 5'h0B, load_misalign 5'h04, store_misalign 5'h06;
  - MRET 5'h10 (`MRET).
- Events are evaluated only when state==IDLE and ex_valid==1. Interrupts are taken only at a valid instruction boundary.
- epc = ex_pc for every event. For interrupts, the instruction at ex_pc is not committed.
- IDLE:
  - On an event (cycle N): latch cause/epc; go to TRAP.
  - No event: all outputs 0.
- TRAP (cycle N+1):
  - exception_flag=1, flush=1, stall_commit=1.
  - exception_target_pc is sampled into redirect_pc at the end of the cycle; go to REDIRECT.
- REDIRECT (cycle N+2 onward):
  - redirect_valid=1, flush=1, stall_commit=1.
  - redirect_pc is held stable until redirect_ready. The handshake completes on a cycle with valid&ready; go to IDLE next cycle.
  - Minimum REDIRECT duration is 1 cycle.
- exception_flag is high for exactly one cycle per event. It is never high in IDLE or REDIRECT.
- Interrupt deasserting after the latch (cycle N) does not cancel the trap.
- Events arriving while not IDLE are ignored; upstream must hold them via stall_commit.
- Simultaneous exception and interrupt: the interrupt wins. The exception re-presents after return.
- Simultaneous ex_mret and any exception: the exception wins.
- Reset asserted mid-sequence: immediate return to IDLE; no redirect is issued.

Optional Feature:
- Macro: TRAP_TVAL_EN.
- When defined:
  - adds input ex_tval (XLEN) and output trap_tval (XLEN);
  - trap_tval is latched with cause and presented during TRAP. It is 0 for interrupts, ecall, ebreak and MRET; ex_tval otherwise.
- When undefined: those ports and registers are absent.

Decomposition:
- Shared defines.v holds:
  - cause codes (CAUSE_*);
  - `MRET;
  - state encoding (TRAP_IDLE=2'd0, TRAP_TRAP=2'd1, TRAP_REDIR=2'd2);
  - interrupt bit position.
- One sub-module, irq_sync: SYNC_STAGES-deep, per-bit synchronizer; clk, active-low asynchronous rst, resets to 0; instantiated once, 3 bits wide.

Test Plan:
- ecall: ex_valid=1, ex_ecall=1, ex_pc=0x8000_0010, target 0x8000_0100, redirect_ready=1.
  - Cycle N+1: exception_flag=1, cause=5'h0B, epc=0x8000_0010.
  - Cycle N+2: redirect_valid=1, redirect_pc=0x8000_0100.
  - Cycle N+3: IDLE.
- Timer interrupt: irq_timer=1, csr_mie=3'b001, mstatus_mie=1, ex_valid with illegal=1.
  - After sync latency, the next valid instruction yields cause=5'h17 (interrupt beats illegal).
  - With mstatus_mie=0: no trap.
- MRET: ex_mret=1, target 0x8000_0044.
  - cause=5'h10 for one cycle, then redirect_pc=0x8000_0044.
- Backpressure: redirect_ready=0 for 4 cycles.
  - redirect_valid and redirect_pc are stable; flush and stall_commit stay 1; exception_flag pulses only once.
- Reset mid-REDIRECT: rst low asynchronously.
  - All outputs 0 immediately; IDLE after release; no stale redirect.
- Priority tie: ex_mret=1 and ex_load_misalign=1 together give cause=5'h04. Inst_misalign and ecall together give cause=5'h00.

Source files
------------

// File: rtl/trap_unit_pkg.sv
// Shared definitions for the trap sequencer: cause codes, FSM state encoding
// and interrupt-bit helpers. TRAP_TVAL_EN enables the trap-value path.
package trap_unit_pkg;

   localparam logic [4:0] CAUSE_INST_MISALIGN  = 5'h00;
   localparam logic [4:0] CAUSE_ILLEGAL        = 5'h02;
   localparam logic [4:0] CAUSE_EBREAK         = 5'h03;
   localparam logic [4:0] CAUSE_LOAD_MISALIGN  = 5'h04;
   localparam logic [4:0] CAUSE_STORE_MISALIGN = 5'h06;
   localparam logic [4:0] CAUSE_ECALL          = 5'h0B;
   localparam logic [4:0] CAUSE_MRET           = 5'h10;
   localparam logic [4:0] CAUSE_IRQ_SOFT       = 5'h13;
   localparam logic [4:0] CAUSE_IRQ_TIMER      = 5'h17;
   localparam logic [4:0] CAUSE_IRQ_EXT        = 5'h1B;

   localparam int CAUSE_IRQ_BIT = 4;
   localparam int NUM_IRQ       = 3;
   localparam int IRQ_EXT_IDX   = 2;
   localparam int IRQ_SOFT_IDX  = 1;
   localparam int IRQ_TIMER_IDX = 0;

   typedef enum logic [1:0] {
      TRAP_IDLE  = 2'd0,
      TRAP_TRAP  = 2'd1,
      TRAP_REDIR = 2'd2
   } trap_state_e;

   // Only address-faulting and illegal-instruction traps carry a meaningful tval.
   function automatic logic tval_applies(input logic [4:0] cause);
      return !cause[CAUSE_IRQ_BIT] &&
             (cause == CAUSE_INST_MISALIGN || cause == CAUSE_ILLEGAL ||
              cause == CAUSE_LOAD_MISALIGN || cause == CAUSE_STORE_MISALIGN);
   endfunction

endpackage

// File: rtl/trap_unit_irq_sync.sv
// Per-bit multi-flop synchronizer for the asynchronous interrupt request lines.
module irq_sync
   import trap_unit_pkg::*;
#(
   parameter int WIDTH  = NUM_IRQ,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);

   logic [STAGES-1:0][WIDTH-1:0] r_chain;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_async};
      end
   end

   assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/trap_unit.sv
// Trap/MRET sequencer in front of the CSR file: picks the highest-priority event,
// pulses the CSR trap inputs, then redirects fetch. TRAP_TVAL_EN adds ex_tval/trap_tval.
module trap_unit
   import trap_unit_pkg::*;
#(
   parameter int XLEN        = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ex_inst_misalign,
   input  logic            ex_illegal,
   input  logic            ex_ebreak,
   input  logic            ex_ecall,
   input  logic            ex_load_misalign,
   input  logic            ex_store_misalign,
   input  logic            ex_mret,
`ifdef TRAP_TVAL_EN
   input  logic [XLEN-1:0] ex_tval,
   output logic [XLEN-1:0] trap_tval,
`endif
   input  logic            irq_ext,
   input  logic            irq_soft,
   input  logic            irq_timer,
   input  logic            csr_mstatus_mie,
   input  logic [2:0]      csr_mie,
   input  logic [XLEN-1:0] exception_target_pc,
   output logic            exception_flag,
   output logic [4:0]      exception_cause,
   output logic [XLEN-1:0] epc,
   output logic            stall_commit,
   output logic            flush,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   input  logic            redirect_ready
);

   logic [NUM_IRQ-1:0] w_irq_sync;
   logic [NUM_IRQ-1:0] w_irq_pend;
   logic               w_event;
   logic [4:0]         w_cause;

   trap_state_e        r_state;
   logic               r_flag;
   logic [4:0]         r_cause;
   logic [XLEN-1:0]    r_epc;
   logic               r_stall;
   logic               r_flush;
   logic               r_rvalid;
   logic [XLEN-1:0]    r_rpc;
`ifdef TRAP_TVAL_EN
   logic [XLEN-1:0]    r_tval;
`endif

   irq_sync #(
      .WIDTH  (NUM_IRQ),
      .STAGES (SYNC_STAGES)
   ) u_irq_sync (
      .clk     (clk),
      .rst     (rst),
      .i_async ({irq_ext, irq_soft, irq_timer}),
      .o_sync  (w_irq_sync)
   );

   assign w_irq_pend = w_irq_sync & csr_mie & {NUM_IRQ{csr_mstatus_mie}};

   // Interrupts outrank exceptions, which outrank MRET.
   always_comb begin
      w_event = 1'b1;
      w_cause = '0;
      if      (w_irq_pend[IRQ_EXT_IDX])   w_cause = CAUSE_IRQ_EXT;
      else if (w_irq_pend[IRQ_SOFT_IDX])  w_cause = CAUSE_IRQ_SOFT;
      else if (w_irq_pend[IRQ_TIMER_IDX]) w_cause = CAUSE_IRQ_TIMER;
      else if (ex_inst_misalign)          w_cause = CAUSE_INST_MISALIGN;
      else if (ex_illegal)                w_cause = CAUSE_ILLEGAL;
      else if (ex_ebreak)                 w_cause = CAUSE_EBREAK;
      else if (ex_ecall)                  w_cause = CAUSE_ECALL;
      else if (ex_load_misalign)          w_cause = CAUSE_LOAD_MISALIGN;
      else if (ex_store_misalign)         w_cause = CAUSE_STORE_MISALIGN;
      else if (ex_mret)                   w_cause = CAUSE_MRET;
      else                                w_event = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= TRAP_IDLE;
         r_flag   <= 1'b0;
         r_cause  <= '0;
         r_epc    <= '0;
         r_stall  <= 1'b0;
         r_flush  <= 1'b0;
         r_rvalid <= 1'b0;
         r_rpc    <= '0;
`ifdef TRAP_TVAL_EN
         r_tval   <= '0;
`endif
      end else begin
         case (r_state)
            TRAP_IDLE: begin
               if (ex_valid && w_event) begin
                  r_state <= TRAP_TRAP;
                  r_flag  <= 1'b1;
                  r_cause <= w_cause;
                  r_epc   <= ex_pc;
                  r_stall <= 1'b1;
                  r_flush <= 1'b1;
`ifdef TRAP_TVAL_EN
                  r_tval  <= tval_applies(w_cause) ? ex_tval : '0;
`endif
               end
            end
            // CSR trap inputs live for one cycle; the CSR's answer becomes the redirect.
            TRAP_TRAP: begin
               r_state  <= TRAP_REDIR;
               r_flag   <= 1'b0;
               r_cause  <= '0;
               r_epc    <= '0;
               r_rvalid <= 1'b1;
               r_rpc    <= exception_target_pc;
`ifdef TRAP_TVAL_EN
               r_tval   <= '0;
`endif
            end
            TRAP_REDIR: begin
               if (redirect_ready) begin
                  r_state  <= TRAP_IDLE;
                  r_rvalid <= 1'b0;
                  r_rpc    <= '0;
                  r_stall  <= 1'b0;
                  r_flush  <= 1'b0;
               end
            end
            default: begin
               r_state  <= TRAP_IDLE;
               r_flag   <= 1'b0;
               r_cause  <= '0;
               r_epc    <= '0;
               r_stall  <= 1'b0;
               r_flush  <= 1'b0;
               r_rvalid <= 1'b0;
               r_rpc    <= '0;
            end
         endcase
      end
   end

   assign exception_flag  = r_flag;
   assign exception_cause = r_cause;
   assign epc             = r_epc;
   assign stall_commit    = r_stall;
   assign flush           = r_flush;
   assign redirect_valid  = r_rvalid;
   assign redirect_pc     = r_rpc;
`ifdef TRAP_TVAL_EN
   assign trap_tval       = r_tval;
`endif

endmodule
